// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared widths and FSM state encoding for the nRisc data-memory access unit.
package unidade_acesso_memoria_pkg;

  localparam int unsigned LARGURA_DADO = 8;
  localparam int unsigned LARGURA_END  = 8;
  localparam int unsigned LARGURA_QTD  = 4;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    ESPERA_DADO = 3'd1,
    ESCRITA     = 3'd2,
    LEITURA     = 3'd3,
    ENTREGA     = 3'd4
  } estado_e;

endpackage

// File: rtl/unidade_acesso_memoria_if.sv
// Request, store/load streams and memory bus of the access unit.
// master = the access unit itself; slave = core plus memory around it.
interface unidade_acesso_memoria_if;
  import unidade_acesso_memoria_pkg::*;

  logic                    ReqValido;
  logic                    ReqPronto;
  logic                    ReqEscrita;
  logic [LARGURA_END-1:0]  ReqEndereco;
  logic [LARGURA_QTD-1:0]  ReqQuantidade;
  logic                    DadoEscValido;
  logic                    DadoEscPronto;
  logic [LARGURA_DADO-1:0] DadoEsc;
  logic                    DadoLidoValido;
  logic                    DadoLidoPronto;
  logic [LARGURA_DADO-1:0] DadoLido;
  logic [LARGURA_END-1:0]  Endereco;
  logic [LARGURA_DADO-1:0] DadoEscritoMem;
  logic                    EscMem;
  logic                    LerMem;
  logic [LARGURA_DADO-1:0] DadoLidoMem;
  logic                    Ocupado;
  logic                    Concluido;

  modport master (
    input  ReqValido, ReqEscrita, ReqEndereco, ReqQuantidade,
    input  DadoEscValido, DadoEsc, DadoLidoPronto, DadoLidoMem,
    output ReqPronto, DadoEscPronto, DadoLidoValido, DadoLido,
    output Endereco, DadoEscritoMem, EscMem, LerMem, Ocupado, Concluido
  );

  modport slave (
    output ReqValido, ReqEscrita, ReqEndereco, ReqQuantidade,
    output DadoEscValido, DadoEsc, DadoLidoPronto, DadoLidoMem,
    input  ReqPronto, DadoEscPronto, DadoLidoValido, DadoLido,
    input  Endereco, DadoEscritoMem, EscMem, LerMem, Ocupado, Concluido
  );

endinterface

// File: rtl/unidade_acesso_memoria_contador_rajada.sv
// Burst bookkeeping: wrapping address incrementer and beats-remaining counter.
module unidade_acesso_memoria_contador_rajada
  import unidade_acesso_memoria_pkg::*;
(
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   carregar,
  input  logic                   avancar,
  input  logic [LARGURA_END-1:0] end_inicial,
  input  logic [LARGURA_QTD-1:0] qtd_inicial,
  output logic [LARGURA_END-1:0] end_atual,
  output logic [LARGURA_END-1:0] end_prox,
  output logic                   ultimo
);

  logic [LARGURA_END-1:0] end_q;
  logic [LARGURA_QTD-1:0] restante_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      end_q      <= '0;
      restante_q <= '0;
    end else if (carregar) begin
      end_q      <= end_inicial;
      restante_q <= qtd_inicial;
    end else if (avancar) begin
      end_q      <= end_prox;
      restante_q <= restante_q - 1'b1;
    end
  end

  // Natural overflow gives the modulo-256 wrap.
  assign end_prox  = end_q + 1'b1;
  assign end_atual = end_q;
  assign ultimo    = (restante_q == '0);

endmodule

// File: rtl/unidade_acesso_memoria.sv
// Initiator side of the data-memory interface: single/burst loads and stores
// with valid/ready streams towards the core and registered memory cycles.
module unidade_acesso_memoria
  import unidade_acesso_memoria_pkg::*;
(
  input logic                      Clock,
  input logic                      Reset,
  unidade_acesso_memoria_if.master barramento
);

  estado_e                 estado;
  logic [LARGURA_END-1:0]  endereco_mem;
  logic [LARGURA_DADO-1:0] dado_esc_mem;
  logic [LARGURA_DADO-1:0] dado_lido;
  logic                    esc_mem;
  logic                    ler_mem;
  logic                    concluido;

  logic                    carregar;
  logic                    avancar;
  logic                    ultimo;
  logic [LARGURA_END-1:0]  end_atual;
  logic [LARGURA_END-1:0]  end_prox;

  assign carregar = (estado == OCIOSO) && barramento.ReqValido;
  assign avancar  = !ultimo && ((estado == ESCRITA) ||
                                ((estado == ENTREGA) && barramento.DadoLidoPronto));

  unidade_acesso_memoria_contador_rajada u_contador (
    .Clock       (Clock),
    .Reset       (Reset),
    .carregar    (carregar),
    .avancar     (avancar),
    .end_inicial (barramento.ReqEndereco),
    .qtd_inicial (barramento.ReqQuantidade),
    .end_atual   (end_atual),
    .end_prox    (end_prox),
    .ultimo      (ultimo)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado       <= OCIOSO;
      endereco_mem <= '0;
      dado_esc_mem <= '0;
      dado_lido    <= '0;
      esc_mem      <= 1'b0;
      ler_mem      <= 1'b0;
      concluido    <= 1'b0;
    end else begin
      concluido <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (barramento.ReqValido) begin
            if (barramento.ReqEscrita) begin
              estado <= ESPERA_DADO;
            end else begin
              // Counter is loaded this same edge, so take the address from the request.
              estado       <= LEITURA;
              endereco_mem <= barramento.ReqEndereco;
              ler_mem      <= 1'b1;
            end
          end
        end
        ESPERA_DADO: begin
          if (barramento.DadoEscValido) begin
            estado       <= ESCRITA;
            endereco_mem <= end_atual;
            dado_esc_mem <= barramento.DadoEsc;
            esc_mem      <= 1'b1;
          end
        end
        ESCRITA: begin
          esc_mem <= 1'b0;
          if (ultimo) begin
            estado    <= OCIOSO;
            concluido <= 1'b1;
          end else begin
            estado <= ESPERA_DADO;
          end
        end
        LEITURA: begin
          ler_mem   <= 1'b0;
          dado_lido <= barramento.DadoLidoMem;
          estado    <= ENTREGA;
        end
        ENTREGA: begin
          if (barramento.DadoLidoPronto) begin
            if (ultimo) begin
              estado    <= OCIOSO;
              concluido <= 1'b1;
            end else begin
              estado       <= LEITURA;
              endereco_mem <= end_prox;
              ler_mem      <= 1'b1;
            end
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign barramento.ReqPronto      = (estado == OCIOSO);
  assign barramento.Ocupado        = (estado != OCIOSO);
  assign barramento.DadoEscPronto  = (estado == ESPERA_DADO);
  assign barramento.DadoLidoValido = (estado == ENTREGA);
  assign barramento.DadoLido       = dado_lido;
  assign barramento.Endereco       = endereco_mem;
  assign barramento.DadoEscritoMem = dado_esc_mem;
  assign barramento.EscMem         = esc_mem;
  assign barramento.LerMem         = ler_mem;
  assign barramento.Concluido      = concluido;

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Bench for unidade_acesso_memoria: memory model, randomized bursts and a
// scoreboard fed by the drivers and drained by a negedge monitor.
module tb_unidade_acesso_memoria;
  import unidade_acesso_memoria_pkg::*;

  typedef struct packed {
    logic [7:0] ender;
    logic [7:0] dado;
  } batida_t;

  logic Clock = 1'b0;
  logic Reset;

  unidade_acesso_memoria_if b ();

  unidade_acesso_memoria dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .barramento (b)
  );

  always #5 Clock = ~Clock;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] dados_esc [16];

  batida_t    exp_esc [$];
  logic [7:0] exp_ler_end [$];
  logic [7:0] exp_ler_dado [$];

  int n_vet = 0;
  int n_erro = 0;
  int conc_emitidos = 0;
  int conc_vistos = 0;
  int stall_fixo = -1;

  task automatic verif(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_vet++;
    if (atual !== esperado) begin
      n_erro++;
      $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic falha(input string nome);
    n_vet++;
    n_erro++;
    $display("FAIL %s: got event/timeout, expected none", nome);
  endtask

  // Reference model: a burst touches addresses ender..ender+qtd modulo 256.
  task automatic registrar(input logic escrita, input logic [7:0] ender, input logic [3:0] qtd);
    logic [7:0] a;
    for (int i = 0; i <= int'(qtd); i++) begin
      a = ender + 8'(i);
      if (escrita) begin
        exp_esc.push_back('{ender: a, dado: dados_esc[i]});
        ref_mem[a] = dados_esc[i];
      end else begin
        exp_ler_end.push_back(a);
        exp_ler_dado.push_back(ref_mem[a]);
      end
    end
    conc_emitidos++;
  endtask

  task automatic pedir(input logic escrita, input logic [7:0] ender, input logic [3:0] qtd,
                       input logic manter);
    logic ok = 1'b0;
    int espera = 0;
    b.ReqValido = 1'b1;
    b.ReqEscrita = escrita;
    b.ReqEndereco = ender;
    b.ReqQuantidade = qtd;
    while (!ok && espera < 100) begin
      @(negedge Clock);
      ok = b.ReqPronto;
      @(posedge Clock);
      #1;
      espera++;
    end
    if (!manter) b.ReqValido = 1'b0;
    if (!ok) falha("req_timeout");
    else registrar(escrita, ender, qtd);
  endtask

  task automatic enviar(input int n, input int gap_max);
    logic ok;
    int espera;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge Clock);
        #1;
      end
      b.DadoEscValido = 1'b1;
      b.DadoEsc = dados_esc[i];
      ok = 1'b0;
      espera = 0;
      while (!ok && espera < 100) begin
        @(negedge Clock);
        ok = b.DadoEscPronto;
        @(posedge Clock);
        #1;
        espera++;
      end
      b.DadoEscValido = 1'b0;
      if (!ok) falha("dado_esc_timeout");
    end
  endtask

  task automatic esperar_fim();
    int espera = 0;
    while (conc_vistos != conc_emitidos && espera < 300) begin
      @(posedge Clock);
      #1;
      espera++;
    end
    if (conc_vistos != conc_emitidos) falha("concluido_timeout");
  endtask

  // MemoriaDados model: read on negedge while LerMem, write on posedge while EscMem.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    b.DadoLidoMem = 8'h00;
    fork
      forever begin
        @(posedge Clock);
        if (b.EscMem) mem[b.Endereco] = b.DadoEscritoMem;
      end
      forever begin
        @(negedge Clock);
        if (b.LerMem) b.DadoLidoMem = mem[b.Endereco];
      end
    join
  end

  // Core-side load consumer: holds DadoLidoPronto low for a chosen number of cycles per beat.
  initial begin
    int cnt = 0;
    int alvo = 0;
    b.DadoLidoPronto = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      if (b.DadoLidoValido) begin
        if (cnt >= alvo) begin
          b.DadoLidoPronto = 1'b1;
        end else begin
          b.DadoLidoPronto = 1'b0;
          cnt++;
        end
      end else begin
        b.DadoLidoPronto = 1'b0;
        cnt = 0;
        alvo = (stall_fixo >= 0) ? stall_fixo : int'($urandom_range(0, 2));
      end
    end
  end

  // Monitor: pops the scoreboard and checks per-cycle invariants.
  initial begin
    logic esc_ant = 1'b0, ler_ant = 1'b0, conc_ant = 1'b0;
    logic valido_ant = 1'b0, pronto_ant = 1'b0;
    logic [7:0] dado_ant = 8'h00;
    batida_t e;
    logic [7:0] v;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        esc_ant = 1'b0; ler_ant = 1'b0; conc_ant = 1'b0;
        valido_ant = 1'b0; pronto_ant = 1'b0;
      end else begin
        verif("esc_ler_exclusivos", 32'(b.EscMem && b.LerMem), 32'd0);
        verif("ocupado_vs_pronto", 32'(b.Ocupado), 32'(!b.ReqPronto));
        if (b.EscMem) begin
          verif("escmem_um_ciclo", 32'(esc_ant), 32'd0);
          if (exp_esc.size() == 0) falha("escrita_inesperada");
          else begin
            e = exp_esc.pop_front();
            verif("esc_endereco", 32'(b.Endereco), 32'(e.ender));
            verif("esc_dado", 32'(b.DadoEscritoMem), 32'(e.dado));
          end
        end
        if (b.LerMem) begin
          verif("lermem_um_ciclo", 32'(ler_ant), 32'd0);
          if (exp_ler_end.size() == 0) falha("leitura_inesperada");
          else begin
            v = exp_ler_end.pop_front();
            verif("ler_endereco", 32'(b.Endereco), 32'(v));
          end
        end
        if (b.DadoLidoValido) begin
          if (!valido_ant) verif("latencia_leitura", 32'(ler_ant), 32'd1);
          if (valido_ant && !pronto_ant) verif("lido_estavel", 32'(b.DadoLido), 32'(dado_ant));
          if (b.DadoLidoPronto) begin
            if (exp_ler_dado.size() == 0) falha("entrega_inesperada");
            else begin
              v = exp_ler_dado.pop_front();
              verif("dado_lido", 32'(b.DadoLido), 32'(v));
            end
          end
        end
        if (b.Concluido) begin
          verif("concluido_largura", 32'(conc_ant), 32'd0);
          if (conc_vistos >= conc_emitidos) falha("concluido_inesperado");
          verif("concluido_filas_vazias", 32'(exp_esc.size() + exp_ler_dado.size()), 32'd0);
          conc_vistos++;
        end
        esc_ant = b.EscMem; ler_ant = b.LerMem; conc_ant = b.Concluido;
        valido_ant = b.DadoLidoValido; pronto_ant = b.DadoLidoPronto;
        dado_ant = b.DadoLido;
      end
    end
  end

  initial begin
    logic [7:0] salvo41, salvo42, a;
    logic [3:0] q;
    logic ok;
    int espera;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    b.ReqValido = 1'b0; b.ReqEscrita = 1'b0; b.ReqEndereco = 8'h00; b.ReqQuantidade = 4'h0;
    b.DadoEscValido = 1'b0; b.DadoEsc = 8'h00;
    Reset = 1'b0;
    #12;
    verif("rst_ReqPronto", 32'(b.ReqPronto), 32'd1);
    verif("rst_Ocupado", 32'(b.Ocupado), 32'd0);
    verif("rst_EscMem", 32'(b.EscMem), 32'd0);
    verif("rst_LerMem", 32'(b.LerMem), 32'd0);
    verif("rst_Endereco", 32'(b.Endereco), 32'd0);
    verif("rst_DadoLido", 32'(b.DadoLido), 32'd0);
    verif("rst_DadoLidoValido", 32'(b.DadoLidoValido), 32'd0);
    verif("rst_Concluido", 32'(b.Concluido), 32'd0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;

    // Single store then single load of 0x10.
    dados_esc[0] = 8'hA5;
    pedir(1'b1, 8'h10, 4'd0, 1'b0);
    enviar(1, 0);
    esperar_fim();
    verif("mem_10", 32'(mem[8'h10]), 32'hA5);
    pedir(1'b0, 8'h10, 4'd0, 1'b0);
    esperar_fim();

    // Wrapping 4-beat store from 0xFE, then load back with 3 stall cycles per beat.
    for (int i = 0; i < 4; i++) dados_esc[i] = 8'(i + 1);
    pedir(1'b1, 8'hFE, 4'd3, 1'b0);
    enviar(4, 2);
    esperar_fim();
    verif("mem_FE", 32'(mem[8'hFE]), 32'h01);
    verif("mem_FF", 32'(mem[8'hFF]), 32'h02);
    verif("mem_00", 32'(mem[8'h00]), 32'h03);
    verif("mem_01", 32'(mem[8'h01]), 32'h04);
    stall_fixo = 3;
    pedir(1'b0, 8'hFE, 4'd3, 1'b0);
    esperar_fim();
    stall_fixo = -1;

    // Stray store beat while idle must not be consumed.
    b.DadoEscValido = 1'b1;
    b.DadoEsc = 8'h77;
    repeat (4) begin
      @(posedge Clock);
      #1;
    end
    b.DadoEscValido = 1'b0;
    verif("stray_ocioso", 32'(b.Ocupado), 32'd0);

    // Request held through a store burst; the next one is taken on the Concluido cycle.
    dados_esc[0] = 8'h5A;
    dados_esc[1] = 8'h6B;
    pedir(1'b1, 8'h80, 4'd1, 1'b1);
    b.ReqEscrita = 1'b0;
    b.ReqEndereco = 8'h80;
    b.ReqQuantidade = 4'd1;
    enviar(2, 1);
    ok = 1'b0;
    espera = 0;
    while (!ok && espera < 50) begin
      @(negedge Clock);
      ok = b.Concluido;
      if (ok) verif("pronto_no_concluido", 32'(b.ReqPronto), 32'd1);
      else verif("pronto_ocupado", 32'(b.ReqPronto), 32'd0);
      @(posedge Clock);
      #1;
      espera++;
    end
    b.ReqValido = 1'b0;
    if (!ok) falha("concluido_rajada_timeout");
    else registrar(1'b0, 8'h80, 4'd1);
    esperar_fim();

    // Reset while waiting for beat 2 of a 3-beat store.
    dados_esc[0] = 8'h11; dados_esc[1] = 8'h22; dados_esc[2] = 8'h33;
    salvo41 = ref_mem[8'h41];
    salvo42 = ref_mem[8'h42];
    pedir(1'b1, 8'h40, 4'd2, 1'b0);
    enviar(1, 0);
    ok = 1'b0;
    espera = 0;
    while (!ok && espera < 20) begin
      @(negedge Clock);
      ok = b.DadoEscPronto;
      espera++;
    end
    if (!ok) falha("espera_beat2_timeout");
    #1;
    Reset = 1'b0;
    #1;
    verif("rstmid_EscMem", 32'(b.EscMem), 32'd0);
    verif("rstmid_LerMem", 32'(b.LerMem), 32'd0);
    verif("rstmid_Ocupado", 32'(b.Ocupado), 32'd0);
    verif("rstmid_Endereco", 32'(b.Endereco), 32'd0);
    verif("rstmid_DadoEscritoMem", 32'(b.DadoEscritoMem), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    verif("rstmid_ReqPronto", 32'(b.ReqPronto), 32'd1);
    verif("rstmid_batidas_pendentes", 32'(exp_esc.size()), 32'd2);
    exp_esc.delete();
    ref_mem[8'h41] = salvo41;
    ref_mem[8'h42] = salvo42;
    conc_emitidos = conc_vistos;
    verif("rstmid_mem40", 32'(mem[8'h40]), 32'h11);
    pedir(1'b0, 8'h40, 4'd2, 1'b0);
    esperar_fim();

    // Randomized store/load pairs.
    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom);
      q = 4'($urandom_range(0, 7));
      for (int i = 0; i < 16; i++) dados_esc[i] = 8'($urandom);
      pedir(1'b1, a, q, 1'b0);
      enviar(int'(q) + 1, 2);
      esperar_fim();
      pedir(1'b0, a, q, 1'b0);
      esperar_fim();
    end

    repeat (3) @(posedge Clock);
    #1;
    verif("filas_finais", 32'(exp_esc.size() + exp_ler_end.size() + exp_ler_dado.size()), 32'd0);
    verif("concluidos_finais", 32'(conc_vistos), 32'(conc_emitidos));
    $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_erro);
    $finish;
  end

endmodule
